// File: rtl/xil_mem_sp_lanes_pkg.sv
// Shared types for the lane-split single-port RAM: clear-engine state encoding.
package xil_mem_sp_lanes_pkg;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/xil_mem_sp_lane.sv
// One lane: DEPTH x LANE_BITS single-port RAM, read-first, registered read output.
// Latency 1; the read register only loads on i_re so it holds between accesses.
module xil_mem_sp_lane #(
    parameter int ADR_BITS  = 9,
    parameter int LANE_BITS = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic                 i_re,
    input  logic [ADR_BITS-1:0]  i_adr,
    input  logic [LANE_BITS-1:0] i_wdata,
    output logic [LANE_BITS-1:0] o_rdata
);

    logic [LANE_BITS-1:0] mem_q [2**ADR_BITS];
    logic [LANE_BITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_adr] <= i_wdata;
        end
    end

    // Separate block so the array stays a plain BRAM with a resettable output latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_adr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/xil_mem_sp_lanes.sv
// Lane-write-enabled single-port RAM with clear engine and optional output register.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); accesses are ignored while o_busy=1.
module xil_mem_sp_lanes
    import xil_mem_sp_lanes_pkg::*;
#(
    parameter int ADR_BITS   = 9,
    parameter int LANES      = 4,
    parameter int LANE_BITS  = 9,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic [LANES-1:0]             i_wen,
    input  logic [ADR_BITS-1:0]          i_adr,
    input  logic [LANES*LANE_BITS-1:0]   i_wdata,
    input  logic                         i_clr,
    output logic [LANES*LANE_BITS-1:0]   o_rdata,
    output logic                         o_rvalid,
    output logic                         o_busy
);

    localparam int W = LANES * LANE_BITS;

    clr_state_e          state_q, state_d;
    logic [ADR_BITS-1:0] cnt_q, cnt_d;
    logic                rv1_q;
    logic                clearing;
    logic                acc;
    logic [ADR_BITS-1:0] mem_adr;
    logic [W-1:0]        lane_rdata;

    assign clearing = (state_q == ST_CLEAR);
    // i_clr takes priority over a same-cycle access.
    assign acc      = (state_q == ST_READY) && i_en && !i_clr;
    assign mem_adr  = clearing ? cnt_q : i_adr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_READY: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == {ADR_BITS{1'b1}}) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv1_q   <= acc;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        xil_mem_sp_lane #(
            .ADR_BITS  (ADR_BITS),
            .LANE_BITS (LANE_BITS)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_we    (clearing || (acc && i_wen[k])),
            .i_re    (acc),
            .i_adr   (mem_adr),
            .i_wdata (clearing ? {LANE_BITS{1'b0}} : i_wdata[k*LANE_BITS +: LANE_BITS]),
            .o_rdata (lane_rdata[k*LANE_BITS +: LANE_BITS])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [W-1:0] out_q;
        logic         rv2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
                rv2_q <= 1'b0;
            end else begin
                rv2_q <= rv1_q;
                if (rv1_q) begin
                    out_q <= lane_rdata;
                end
            end
        end

        assign o_rdata  = out_q;
        assign o_rvalid = rv2_q;
    end else begin : g_no_out_reg
        assign o_rdata  = lane_rdata;
        assign o_rvalid = rv1_q;
    end

    assign o_busy = clearing;

endmodule

// File: tb/tb_xil_mem_sp_lanes.sv
// Drives two instances (OUT_REG=0 and OUT_REG=1) with identical stimulus and
// compares both against a word-array model with per-instance result pipelines.
module tb_xil_mem_sp_lanes;

    localparam int AB    = 4;
    localparam int DEPTH = 16;
    localparam int LN    = 4;
    localparam int LB    = 9;
    localparam int W     = LN * LB;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [LN-1:0] wen;
    logic [AB-1:0] adr;
    logic [W-1:0]  wdata;
    logic          clr;

    logic [W-1:0]  rdata0, rdata1;
    logic          rvalid0, rvalid1, busy0, busy1;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] m_mem [DEPTH];
    int           m_clr_left;
    logic         m_v1, m_v2;
    logic [W-1:0] m_d1, m_d2;

    always #5 clk = ~clk;

    xil_mem_sp_lanes #(
        .ADR_BITS(AB), .LANES(LN), .LANE_BITS(LB), .OUT_REG(0), .INIT_CLEAR(1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .i_en(en), .i_wen(wen), .i_adr(adr), .i_wdata(wdata),
        .i_clr(clr), .o_rdata(rdata0), .o_rvalid(rvalid0), .o_busy(busy0)
    );

    xil_mem_sp_lanes #(
        .ADR_BITS(AB), .LANES(LN), .LANE_BITS(LB), .OUT_REG(1), .INIT_CLEAR(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .i_en(en), .i_wen(wen), .i_adr(adr), .i_wdata(wdata),
        .i_clr(clr), .o_rdata(rdata1), .o_rvalid(rvalid1), .o_busy(busy1)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en_a, input logic [LN-1:0] wen_a, input logic [AB-1:0] adr_a,
                        input logic [W-1:0] wd_a, input logic clr_a, input logic rst_a);
        logic         nv2;
        logic [W-1:0] nd2;
        en = en_a; wen = wen_a; adr = adr_a; wdata = wd_a; clr = clr_a; rst = rst_a;
        @(posedge clk);
        if (rst_a) begin
            m_v1 = 1'b0; m_d1 = '0; m_v2 = 1'b0; m_d2 = '0;
            m_clr_left = DEPTH;
        end else begin
            nv2 = m_v1;
            nd2 = m_v1 ? m_d1 : m_d2;
            if (m_clr_left > 0) begin
                m_mem[DEPTH - m_clr_left] = '0;
                m_clr_left--;
                m_v1 = 1'b0;
            end else if (clr_a) begin
                m_clr_left = DEPTH;
                m_v1 = 1'b0;
            end else if (en_a) begin
                m_d1 = m_mem[adr_a];
                for (int k = 0; k < LN; k++)
                    if (wen_a[k]) m_mem[adr_a][k*LB +: LB] = wd_a[k*LB +: LB];
                m_v1 = 1'b1;
            end else begin
                m_v1 = 1'b0;
            end
            m_v2 = nv2;
            m_d2 = nd2;
        end
        #1;
        chk("busy0",   W'(busy0),   W'(m_clr_left > 0));
        chk("busy1",   W'(busy1),   W'(m_clr_left > 0));
        chk("rvalid0", W'(rvalid0), W'(m_v1));
        chk("rvalid1", W'(rvalid1), W'(m_v2));
        chk("rdata0",  rdata0,      m_d1);
        chk("rdata1",  rdata1,      m_d2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [AB-1:0] a);
        step(1'b1, '0, a, W'({$urandom(), $urandom()}), 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [W-1:0] d, input logic [LN-1:0] we);
        step(1'b1, we, a, d, 1'b0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_clr_left = DEPTH;
        m_v1 = 1'b0; m_v2 = 1'b0; m_d1 = '0; m_d2 = '0;

        // Reset and the automatic clear: busy for exactly DEPTH cycles.
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("reset_rdata0", rdata0, '0);
        busy_cnt = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (busy0) busy_cnt++;
            idle(1);
        end
        chk("init_busy_len", W'(busy_cnt), W'(DEPTH));
        for (int a = 0; a < DEPTH; a++) rd(AB'(a));
        idle(2);

        // Lane-merge write.
        wr(4'd5, 36'h1_2345_6789, 4'b1111);
        wr(4'd5, 36'h0_0000_01FF, 4'b0001);
        rd(4'd5);
        idle(1);
        chk("lane_merge", rdata0, 36'h1_2345_67FF);

        // Read-first.
        wr(4'd3, 36'h0_0000_0AAA, 4'b1111);
        wr(4'd3, 36'h0_0000_0555, 4'b1111);
        chk("read_first", rdata0, 36'h0_0000_0AAA);
        rd(4'd3);
        idle(1);

        // Back-to-back reads through both latencies.
        for (int a = 0; a < 8; a++) wr(AB'(a), W'({$urandom(), $urandom()}), 4'b1111);
        for (int a = 0; a < 8; a++) rd(AB'(a));
        idle(3);

        // Clear and access together: clear wins.
        step(1'b1, 4'b1111, 4'd2, 36'h5_5555_5555, 1'b1, 1'b0);
        idle(DEPTH + 1);
        for (int a = 0; a < DEPTH; a++) rd(AB'(a));
        idle(2);

        // Reset at clear count 7 restarts the clear; accesses meanwhile are ignored.
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle(7);
        step(1'b1, 4'b1111, 4'd1, 36'h3_3333_3333, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (busy0) busy_cnt++;
            step(1'b1, 4'b1111, AB'($urandom_range(0, DEPTH - 1)), W'({$urandom(), $urandom()}), 1'b0, 1'b0);
        end
        chk("rst_mid_clear_busy_len", W'(busy_cnt), W'(DEPTH));

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, LN'($urandom()), AB'($urandom()),
                 W'({$urandom(), $urandom()}), $urandom_range(0, 59) == 0,
                 $urandom_range(0, 199) == 0);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
